uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//  Parametrised UART transmitter, successor to the fixed 8N1 tx. Serialises words with
//  configurable data width, parity mode and stop-bit count, paced by the shared
//  baud_rate_generator tick. A one-entry holding register with valid/ready handshake
//  gives back-to-back frames with no idle bit between them.
// PARAMETERS
//  NB_DATA    8   data bits per frame (5..9), sent LSB first
//  OVERSAMPLE 16  i_tick pulses per bit period (>=2)
//  PARITY     0   0 = none, 1 = even, 2 = odd
//  NB_STOP    1   stop bits (1 or 2)
// PORTS
//  i_clk      in   1        system clock
//  i_reset_n  in   1        asynchronous reset, active low
//  i_tick     in   1        one-cycle baud-tick pulse from baud_rate_generator
//  i_valid    in   1        i_data is valid; a transfer occurs when i_valid & o_ready
//  i_data     in   NB_DATA  word to transmit
//  o_ready    out  1        holding register empty; can accept a word
//  o_tx_data  out  1        serial line, idle high, registered
//  o_busy     out  1        FSM not in IDLE
//  o_done     out  1        one-cycle pulse on the last tick of the final stop bit
// BEHAVIOUR
//  Reset (async, i_reset_n=0): o_tx_data=1, o_ready=1, o_busy=0, o_done=0; FSM=IDLE;
//   hold, shift and counters cleared. Assert mid-frame -> line high at once, frame and
//   held word are dropped. No partial frame resumes after release.
//  Handshake: o_ready = ~hold_full (combinational). On i_valid & o_ready, latch i_data
//   into hold and set hold_full. If i_valid is high while o_ready=0, the word is ignored.
//   i_valid does not need to be held.
//  FSM: IDLE, START, DATA, PAR, STOP.
//   IDLE:  line=1. If hold_full: shift<=hold, parity<=^hold (^1 if odd), clear hold_full,
//          tick_cnt=0, go to START. hold_full sets on the cycle after the transfer, so
//          latency from accepted i_valid to line low is 2 clocks.
//   START: line=0 for OVERSAMPLE ticks -> DATA, bit_cnt=0.
//   DATA:  line=shift[0]; after OVERSAMPLE ticks shift>>=1, bit_cnt++. After bit
//          NB_DATA-1: go to PAR if PARITY!=0, else go to STOP.
//   PAR:   line=parity bit for OVERSAMPLE ticks -> STOP.
//   STOP:  line=1 for NB_STOP*OVERSAMPLE ticks. On the last tick pulse o_done and go
//          to IDLE. If hold_full, START is entered 1 clock later, so the gap is < 1 tick.
//  Counters: tick_cnt counts i_tick only, width $clog2(NB_STOP*OVERSAMPLE), and wraps
//   to 0 at each bit boundary. bit_cnt width $clog2(NB_DATA+1).
//  Simultaneous events: IDLE load and a new transfer in the same cycle -> hold_full stays
//   1 with the new word (clear has lower priority than set). An i_tick during the IDLE
//   load cycle is not counted.
//  i_tick held high continuously is legal: each bit then lasts OVERSAMPLE clocks.
//  o_busy=1 in every state except IDLE.
// STRUCTURE
//  Shared package uart_pkg: state encodings (ST_IDLE..ST_STOP), parity-mode constants
//   PAR_NONE/PAR_EVEN/PAR_ODD, default OVERSAMPLE. baud_rate_generator imports the
//   same package.
//  One natural sub-module: uart_tx_hold (1-entry holding register + valid/ready). The
//   FSM, counters and shifter stay in this module.
// TESTING (bench drives i_tick=1 every clock unless stated; OVERSAMPLE=16)
//  1 Reset: hold i_reset_n=0 with i_valid=1 -> o_tx_data=1, o_ready=1, o_busy=0, no frame.
//  2 8N1, i_data=8'hF0 -> line 0, 0,0,0,0,1,1,1,1, 1; 16 clocks per bit; o_done at
//    clock 160 after start; o_ready=1 again one clock after transfer.
//  3 PARITY=1, NB_STOP=2, i_data=8'h07 -> data bits then parity=1, then 32 high clocks.
//    Repeat with PARITY=2 -> parity=0.
//  4 Back-to-back: send 8'hA5 then 8'h3C during the first frame -> second start bit
//    begins 1 clock after o_done. A third word offered while full is dropped (o_ready=0).
//  5 Reset mid-DATA of 8'h55 (bit 3) -> line high same cycle; after release, idle and
//    no o_done.
//  6 Real baud_rate_generator ticks, NB_DATA=7, i_data=7'h41 -> each bit lasts exactly
//    16 ticks; sampling at bit centres with a reference model returns 7'h41.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default timing constants.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_BAUD_DIV   = 27;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/baud_rate_generator.sv
// Baud tick source: one-cycle o_tick every DIVISOR clocks, registered.
// Free-running from reset; no handshake, consumers simply sample the pulse.
module baud_rate_generator
    import uart_pkg::*;
#(
    parameter int DIVISOR = DEF_BAUD_DIV
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_tick
);

    localparam int            CW   = cnt_width(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_tx_hold.sv
// One-entry holding register: word appears on o_data/o_full the clock after i_valid & o_ready.
// o_ready drops while full; offers made then are ignored. i_load empties it (a new accept wins).
module uart_tx_hold #(
    parameter int NB_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_ready,
    input  logic               i_load,
    output logic               o_full,
    output logic [NB_DATA-1:0] o_data
);

    logic               r_full;
    logic [NB_DATA-1:0] r_data;
    logic               w_accept;

    assign w_accept = i_valid & ~r_full;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_load) begin
            r_full <= 1'b0;
        end
    end

    assign o_ready = ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/uart_tx_framer.sv
// Parametrised UART tx: start, NB_DATA bits LSB first, optional parity, NB_STOP stop bits.
// Line goes low 2 clocks after an accepted word; a held word starts 1 clock after o_done.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY     = PAR_NONE,
    parameter int NB_STOP    = 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_tick,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_ready,
    output logic               o_tx_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam int                TICK_W    = cnt_width(NB_STOP * OVERSAMPLE);
    localparam int                BIT_W     = cnt_width(NB_DATA + 1);
    localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(NB_STOP * OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_DATA - 1);
    localparam logic              ODD_FLIP  = (PARITY == PAR_ODD);

    uart_state_t        r_state, w_state_nxt;
    logic [NB_DATA-1:0] r_shift, w_shift_nxt;
    logic               r_parity, w_parity_nxt;
    logic [TICK_W-1:0]  r_tick_cnt, w_tick_nxt;
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_nxt;
    logic               r_tx, w_tx_nxt;
    logic               r_done, w_done_nxt;
    logic               w_load;
    logic               w_hold_full;
    logic [NB_DATA-1:0] w_hold_dat;
    logic               w_bit_end;
    logic               w_stop_end;

    uart_tx_hold #(
        .NB_DATA (NB_DATA)
    ) u_hold (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .i_load    (w_load),
        .o_full    (w_hold_full),
        .o_data    (w_hold_dat)
    );

    assign w_bit_end  = i_tick && (r_tick_cnt == OS_LAST);
    assign w_stop_end = i_tick && (r_tick_cnt == STOP_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_tick_nxt   = r_tick_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_tx_nxt     = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_hold_full) begin
                    w_load       = 1'b1;
                    w_shift_nxt  = w_hold_dat;
                    w_parity_nxt = (^w_hold_dat) ^ ODD_FLIP;
                    w_tick_nxt   = '0;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else if (i_tick) begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_tick_nxt  = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end else if (i_tick) begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end
            ST_PAR: begin
                if (w_bit_end) begin
                    w_tick_nxt  = '0;
                    w_state_nxt = ST_STOP;
                end else if (i_tick) begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_stop_end) begin
                    w_tick_nxt  = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (i_tick) begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Line is registered from next-state values so it changes with the state itself.
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            ST_PAR:   w_tx_nxt = w_parity_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign o_tx_data = r_tx;
    assign o_done    = r_done;
    assign o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four configurations (8N1, 8E2, 8O2, 7N1 on real baud ticks)
// checked clock by clock against a frame-level model of the serial line.
module tb_uart_tx_framer;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick_one = 1'b1;
    logic [3:0] vld      = '0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0] d3 = '0;
    wire  [3:0] tx, rdy, busy, done;
    wire        w_bt;

    int vectors     = 0;
    int miscompares = 0;

    logic q_line[$];
    logic q_busy[$];
    logic q_done[$];

    always #5 clk = ~clk;

    uart_tx_framer #(.NB_DATA(8), .OVERSAMPLE(16), .PARITY(0), .NB_STOP(1)) u_8n1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick_one), .i_valid(vld[0]), .i_data(d0),
        .o_ready(rdy[0]), .o_tx_data(tx[0]), .o_busy(busy[0]), .o_done(done[0]));

    uart_tx_framer #(.NB_DATA(8), .OVERSAMPLE(16), .PARITY(1), .NB_STOP(2)) u_8e2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick_one), .i_valid(vld[1]), .i_data(d1),
        .o_ready(rdy[1]), .o_tx_data(tx[1]), .o_busy(busy[1]), .o_done(done[1]));

    uart_tx_framer #(.NB_DATA(8), .OVERSAMPLE(16), .PARITY(2), .NB_STOP(2)) u_8o2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick_one), .i_valid(vld[2]), .i_data(d2),
        .o_ready(rdy[2]), .o_tx_data(tx[2]), .o_busy(busy[2]), .o_done(done[2]));

    baud_rate_generator #(.DIVISOR(3)) u_bg (
        .i_clk(clk), .i_reset_n(rst_n), .o_tick(w_bt));

    uart_tx_framer #(.NB_DATA(7), .OVERSAMPLE(16), .PARITY(0), .NB_STOP(1)) u_7n1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_tick(w_bt), .i_valid(vld[3]), .i_data(d3),
        .o_ready(rdy[3]), .o_tx_data(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic clear_q();
        q_line.delete();
        q_busy.delete();
        q_done.delete();
    endtask

    // Expected line per clock for one frame at one tick per clock, then the o_done clock.
    task automatic model_frame(input int nd, input int par, input int ns, input logic [8:0] w);
        logic bits[$];
        int   ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(w[i]);
            if (w[i]) ones++;
        end
        if (par == 1) bits.push_back((ones % 2) == 1);
        if (par == 2) bits.push_back((ones % 2) == 0);
        for (int s = 0; s < ns; s++) bits.push_back(1'b1);
        foreach (bits[b]) begin
            repeat (16) begin
                q_line.push_back(bits[b]);
                q_busy.push_back(1'b1);
                q_done.push_back(1'b0);
            end
        end
        q_line.push_back(1'b1);
        q_busy.push_back(1'b0);
        q_done.push_back(1'b1);
    endtask

    task automatic model_idle(input int n);
        repeat (n) begin
            q_line.push_back(1'b1);
            q_busy.push_back(1'b0);
            q_done.push_back(1'b0);
        end
    endtask

    task automatic set_data(input int idx, input logic [8:0] w);
        case (idx)
            0:       d0 = w[7:0];
            1:       d1 = w[7:0];
            2:       d2 = w[7:0];
            default: d3 = w[6:0];
        endcase
    endtask

    // Returns #1 after the accepting clock edge.
    task automatic send(input int idx, input logic [8:0] w);
        @(posedge clk); #1;
        set_data(idx, w);
        vld[idx] = 1'b1;
        @(posedge clk); #1;
        vld[idx] = 1'b0;
    endtask

    task automatic test_reset();
        vld = 4'hF;
        d0 = 8'($urandom_range(0, 255));
        d1 = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        d3 = 7'($urandom_range(0, 127));
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (tx !== 4'hF || rdy !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_hold tx=%b rdy=%b busy=%b done=%b exp 1111 1111 0000 0000",
                         tx, rdy, busy, done);
            end
        end
        vld = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 4'hF || rdy !== 4'hF || busy !== 4'h0 || done !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_release tx=%b rdy=%b busy=%b done=%b exp 1111 1111 0000 0000",
                     tx, rdy, busy, done);
        end
    endtask

    task automatic test_frames(input string name, input int idx, input int par, input int ns,
                               input logic [8:0] first, input int count);
        logic [8:0] w;
        for (int n = 0; n < count; n++) begin
            w = (n == 0) ? first : 9'($urandom_range(0, 255));
            clear_q();
            model_frame(8, par, ns, w);
            model_idle(3);
            send(idx, w);
            @(negedge clk);
            vectors++;
            if (rdy[idx] !== 1'b0 || tx[idx] !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_accept w=%h rdy=%b tx=%b exp rdy=0 tx=1", name, w, rdy[idx], tx[idx]);
            end
            for (int k = 0; k < q_line.size(); k++) begin
                @(negedge clk);
                vectors++;
                if (tx[idx] !== q_line[k] || busy[idx] !== q_busy[k] || done[idx] !== q_done[k] ||
                    (k == 0 && rdy[idx] !== 1'b1)) begin
                    miscompares++;
                    $display("FAIL %s_line w=%h clk=%0d tx/busy/done/rdy=%b%b%b%b exp %b%b%b%b",
                             name, w, k + 1, tx[idx], busy[idx], done[idx], rdy[idx],
                             q_line[k], q_busy[k], q_done[k], (k == 0) ? 1'b1 : rdy[idx]);
                end
            end
        end
    endtask

    task automatic test_8n1();
        test_frames("8n1", 0, 0, 1, 9'h0F0, 5);
    endtask

    task automatic test_parity();
        test_frames("8e2", 1, 1, 2, 9'h007, 4);
        test_frames("8o2", 2, 2, 2, 9'h007, 4);
    endtask

    task automatic test_back_to_back();
        logic [8:0] w3;
        w3 = 9'($urandom_range(0, 255));
        clear_q();
        model_frame(8, 0, 1, 9'h0A5);
        model_frame(8, 0, 1, 9'h03C);
        model_idle(40);
        send(0, 9'h0A5);
        @(negedge clk);
        for (int k = 0; k < q_line.size(); k++) begin
            @(negedge clk);
            vectors++;
            if (tx[0] !== q_line[k] || busy[0] !== q_busy[k] || done[0] !== q_done[k]) begin
                miscompares++;
                $display("FAIL b2b_line clk=%0d tx/busy/done=%b%b%b exp %b%b%b",
                         k + 1, tx[0], busy[0], done[0], q_line[k], q_busy[k], q_done[k]);
            end
            if (k == 19) begin
                d0     = 8'h3C;
                vld[0] = 1'b1;
            end
            if (k == 20) vld[0] = 1'b0;
            if (k == 29 || k == 160 || k == 161) begin
                vectors++;
                if (rdy[0] !== (k == 161)) begin
                    miscompares++;
                    $display("FAIL b2b_ready clk=%0d rdy=%b exp %b", k + 1, rdy[0], (k == 161));
                end
            end
            if (k == 29) begin
                d0     = w3[7:0];
                vld[0] = 1'b1;
            end
            if (k == 30) vld[0] = 1'b0;
        end
    endtask

    task automatic test_baud();
        logic [8:0] w;
        logic [6:0] got;
        logic       found;
        logic       eb;
        int         j;
        int         b;
        int         cyc;
        for (int n = 0; n < 3; n++) begin
            w     = (n == 0) ? 9'h041 : 9'($urandom_range(0, 127));
            got   = '0;
            found = 1'b0;
            send(3, w);
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                if (tx[3] === 1'b0) found = 1'b1;
            end
            vectors++;
            if (!found) begin
                miscompares++;
                $display("FAIL baud_start w=%h tx stayed %b exp 0 within 40 clocks", w, tx[3]);
            end
            j   = 0;
            cyc = 0;
            while (found && j < 144 && cyc < 3000) begin
                if (w_bt === 1'b1) begin
                    b  = j / 16;
                    eb = (b == 0) ? 1'b0 : (b <= 7) ? w[b-1] : 1'b1;
                    vectors++;
                    if (tx[3] !== eb) begin
                        miscompares++;
                        $display("FAIL baud_bit w=%h tick=%0d bit=%0d tx=%b exp %b", w, j, b, tx[3], eb);
                    end
                    if (j % 16 == 8 && b >= 1 && b <= 7) got[b-1] = tx[3];
                    j++;
                end
                if (j < 144) begin
                    @(negedge clk);
                    cyc++;
                end
            end
            @(negedge clk);
            vectors++;
            if (done[3] !== 1'b1 || j != 144) begin
                miscompares++;
                $display("FAIL baud_done w=%h done=%b ticks=%0d exp done=1 ticks=144", w, done[3], j);
            end
            vectors++;
            if (got !== w[6:0]) begin
                miscompares++;
                $display("FAIL baud_decode got=%h exp %h", got, w[6:0]);
            end
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        model_frame(8, 0, 1, 9'h055);
        send(0, 9'h055);
        @(negedge clk);
        for (int k = 0; k <= 68; k++) begin
            @(negedge clk);
            vectors++;
            if (tx[0] !== q_line[k] || busy[0] !== q_busy[k]) begin
                miscompares++;
                $display("FAIL rmid_line clk=%0d tx/busy=%b%b exp %b%b", k + 1, tx[0], busy[0],
                         q_line[k], q_busy[k]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rdy[0] !== 1'b1 || done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_async tx/busy/rdy/done=%b%b%b%b exp 1010", tx[0], busy[0], rdy[0], done[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            vectors++;
            if (tx[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL rmid_after clk=%0d tx/done/busy=%b%b%b exp 100", k, tx[0], done[0], busy[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_baud();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
